// File: rtl/stack_pkg.sv
// Shared constants for the stack engine: opcodes, error codes and FSM states.
package stack_pkg;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_PUSH = 3'd1;
  localparam logic [2:0] OP_POP  = 3'd2;
  localparam logic [2:0] OP_DUP  = 3'd3;
  localparam logic [2:0] OP_SWAP = 3'd4;
  localparam logic [2:0] OP_OVER = 3'd5;
  localparam logic [2:0] OP_ADD  = 3'd6;
  localparam logic [2:0] OP_SUB  = 3'd7;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_OVF  = 2'd1;
  localparam logic [1:0] ERR_UNF  = 2'd2;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_ERR = 1'b1
  } state_e;

endpackage

// File: rtl/stack_alu.sv
// Combinational add/sub of second (n) and top (t) entries; wraps modulo 2^WIDTH.
module stack_alu #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] n_i,
  input  logic [WIDTH-1:0] t_i,
  input  logic             sub_i,
  output logic [WIDTH-1:0] res_o
);

  assign res_o = sub_i ? (n_i - t_i) : (n_i + t_i);

endmodule

// File: rtl/stack_engine.sv
// Parametrised shift-array stack with DUP/SWAP/OVER/ADD/SUB and a latched
// overflow/underflow error state that blocks ops until clear.
module stack_engine
  import stack_pkg::*;
#(
  parameter  int WIDTH = 4,
  parameter  int DEPTH = 8,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] v0,
  output logic [WIDTH-1:0] v1,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             err,
  output logic [1:0]       err_code
);

  // Handshake: an op is taken on a rising edge when op_valid && op_ready;
  // op_ready depends only on state, and nothing needs to be held when ready=0.

  logic [WIDTH-1:0] stk_q [DEPTH];
  logic [WIDTH-1:0] stk_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  state_e           state_q, state_d;
  logic [1:0]       err_code_q, err_code_d;

  logic             accept;
  logic             need_one, need_two, grows;
  logic             unf, ovf;
  logic [WIDTH-1:0] alu_res;

  stack_alu #(.WIDTH(WIDTH)) u_alu (
    .n_i   (stk_q[1]),
    .t_i   (stk_q[0]),
    .sub_i (op[0]),
    .res_o (alu_res)
  );

  assign op_ready = (state_q == ST_RUN);
  assign accept   = op_valid && op_ready;

  // Underflow is checked first so an op failing both checks reports underflow.
  always_comb begin
    need_one = 1'b0;
    need_two = 1'b0;
    grows    = 1'b0;
    case (op)
      OP_PUSH: grows    = 1'b1;
      OP_POP:  need_one = 1'b1;
      OP_DUP:  begin need_one = 1'b1; grows = 1'b1; end
      OP_SWAP: need_two = 1'b1;
      OP_OVER: begin need_two = 1'b1; grows = 1'b1; end
      OP_ADD:  need_two = 1'b1;
      OP_SUB:  need_two = 1'b1;
      default: ;
    endcase
    unf = (need_one && (count_q == '0)) || (need_two && (count_q < CW'(2)));
    ovf = grows && (count_q == CW'(DEPTH));
  end

  always_comb begin
    stk_d      = stk_q;
    count_d    = count_q;
    state_d    = state_q;
    err_code_d = err_code_q;
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) stk_d[i] = '0;
      count_d    = '0;
      state_d    = ST_RUN;
      err_code_d = ERR_NONE;
    end else if (accept) begin
      if (unf) begin
        state_d    = ST_ERR;
        err_code_d = ERR_UNF;
      end else if (ovf) begin
        state_d    = ST_ERR;
        err_code_d = ERR_OVF;
      end else begin
        case (op)
          OP_PUSH, OP_DUP, OP_OVER: begin
            // Bottom slot is empty whenever there is room, so nothing is lost.
            for (int i = 1; i < DEPTH; i++) stk_d[i] = stk_q[i-1];
            if (op == OP_PUSH)     stk_d[0] = data_in;
            else if (op == OP_DUP) stk_d[0] = stk_q[0];
            else                   stk_d[0] = stk_q[1];
            count_d = count_q + CW'(1);
          end
          OP_POP: begin
            for (int i = 0; i < DEPTH - 1; i++) stk_d[i] = stk_q[i+1];
            stk_d[DEPTH-1] = '0;
            count_d = count_q - CW'(1);
          end
          OP_SWAP: begin
            stk_d[0] = stk_q[1];
            stk_d[1] = stk_q[0];
          end
          OP_ADD, OP_SUB: begin
            stk_d[0] = alu_res;
            for (int i = 1; i < DEPTH - 1; i++) stk_d[i] = stk_q[i+1];
            stk_d[DEPTH-1] = '0;
            count_d = count_q - CW'(1);
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stk_q[i] <= '0;
      count_q    <= '0;
      state_q    <= ST_RUN;
      err_code_q <= ERR_NONE;
    end else begin
      stk_q      <= stk_d;
      count_q    <= count_d;
      state_q    <= state_d;
      err_code_q <= err_code_d;
    end
  end

  assign v0       = stk_q[0];
  assign v1       = stk_q[1];
  assign count    = count_q;
  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign err      = (state_q == ST_ERR);
  assign err_code = err_code_q;

endmodule

// File: doc/stack_engine.md
Name: stack_engine

Overview:
- Parametrised successor to the fixed 4-bit push/pop stack. It adds configurable width and depth, occupancy tracking, and full/empty flags.
- Adds stack-manipulation and arithmetic ops: DUP, SWAP, OVER, ADD, SUB.
- Overflow/underflow are detected and latched into an error state that blocks further ops until cleared.
- Sits between the op decoder and the output multiplexer in the stack CPU; exposes the top two entries.

Parameters:
- WIDTH, 4, bits per stack entry.
- DEPTH, 8, number of entries (>=2).
- CW, $clog2(DEPTH+1), width of the occupancy count (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-high; clears all state.
- clear  in  1  synchronous flush: empties the stack and clears the error state.
- op_valid  in  1  an op is presented this cycle.
- op_ready  out  1  engine accepts ops (combinational from state: 1 in RUN, 0 in ERR).
- op  in  3  opcode: 0 NOP, 1 PUSH, 2 POP, 3 DUP, 4 SWAP, 5 OVER, 6 ADD, 7 SUB.
- data_in  in  WIDTH  operand for PUSH.
- v0  out  WIDTH  top of stack (registered).
- v1  out  WIDTH  second entry (registered).
- count  out  CW  current occupancy, 0..DEPTH.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- err  out  1  state==ERR.
- err_code  out  2  0 none, 1 overflow, 2 underflow; held while in ERR.

Behaviour:
- Storage is a shift array: entry 0 = top. Slots at index >= count always hold 0, so v0/v1 read 0 when absent.
- Reset (async, any time, including mid-op): all entries 0, count 0, state RUN, err_code 0. Thus v0=v1=0, empty=1, full=0, err=0, op_ready=1.
- An op is accepted on a clk edge when op_valid & op_ready. Results are visible on outputs the following cycle (latency 1). One op per cycle, back-to-back allowed.
- Op semantics, with c=count, T=top, N=second:
  - PUSH: shift down, top=data_in, c+1.
  - POP: shift up, zero fills bottom, c-1.
  - DUP: push T, c+1.
  - OVER: push N, c+1.
  - SWAP: exchange T and N, c unchanged.
  - ADD: pop both, push (N+T) mod 2^WIDTH, c-1.
  - SUB: pop both, push (N-T) mod 2^WIDTH, c-1.
  - NOP: no change.
- Preconditions:
  - PUSH, DUP and OVER need c<DEPTH, else overflow.
  - POP and DUP need c>=1.
  - SWAP, OVER, ADD and SUB need c>=2.
  - A violated minimum-count check is underflow.
  - OVER at c==DEPTH with c>=2 is overflow. An op that violates both checks (e.g. OVER with c<2 and DEPTH tiny) reports underflow.
- On a violation:
  - Stack contents and count are unchanged.
  - Next state is ERR; err_code = 1 or 2.
- State machine, two states:
  - RUN -> ERR on a violating accepted op.
  - ERR -> RUN only on clear.
  - In ERR, op_ready=0 and op_valid is ignored; outputs keep showing the frozen stack for debug.
- clear has priority over any op in the same cycle. Next cycle: all entries 0, count 0, RUN, err_code 0.
- Arithmetic wraps silently; there is no carry/borrow flag.
- op_valid with op_ready=0 has no effect. No holding requirement on the producer.

Decomposition:
- stack_pkg: opcode constants (OP_NOP..OP_SUB), err_code constants (ERR_NONE, ERR_OVF, ERR_UNF), state encoding (ST_RUN, ST_ERR).
- Sub-module stack_alu: combinational WIDTH-bit add/sub of N and T, selected by op[0]. It is reused later by the CPU datapath.
- Precondition checking, the state machine and the shift array stay in stack_engine.

Test Plan:
1. Reset then PUSH 3, PUSH 5 -> v0=5, v1=3, count=2. Then ADD -> v0=8, v1=0, count=1, err=0.
2. PUSH 2, PUSH 7, SUB -> v0=0xB (2-7 mod 16), count=1. Then DUP, SWAP -> v0=v1=0xB, count=2.
3. PUSH 1..8 back-to-back -> full=1, count=8, v0=8, v1=7. A 9th PUSH 9 -> err=1, err_code=1, op_ready=0, v0 still 8. Further POP ignored. clear -> count=0, empty=1, err=0, op_ready=1.
4. From empty, POP -> err_code=2, count=0. clear and op_valid with PUSH in same cycle -> clear wins, count=0, next cycle PUSH 4 accepted -> v0=4.
5. PUSH 6, OVER with count=1 -> underflow (err_code=2), v0=6 unchanged. After clear: PUSH 6, PUSH 9, OVER -> v0=6, v1=9, count=3.
6. Assert rst asynchronously (between edges) while count=5 in RUN -> outputs zero immediately: count=0, empty=1, v0=v1=0, err=0. Also with WIDTH=8, DEPTH=4: PUSH 0xFF, PUSH 0x02, ADD -> v0=0x01.
